// File: rtl/inst_loader.sv
// Packs UART bytes little-endian into 32-bit words and writes them to consecutive imem addresses.
// Latency: one cycle from the 4th byte to the write strobe. Backpressure: none; a byte may arrive every cycle.
// Loading ends after the HALT word is written, or after the last memory slot is filled.
module inst_loader #(
    parameter int               NB_DATA    = 32,
    parameter int               NBYTE      = 8,
    parameter int               N_ELEMENTS = 128,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hfc000000
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [NBYTE-1:0]   byte_i,
    input  logic               byte_valid_i,
    output logic               en_write_o,
    output logic [NB_DATA-1:0] addr_write_o,
    output logic [NB_DATA-1:0] data_write_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [NB_DATA-1:0] word_count_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;
    localparam int         SR_W     = NB_DATA - NBYTE;
    localparam logic [NB_DATA-1:0] LAST_IDX = NB_DATA'(N_ELEMENTS - 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         bidx_q, bidx_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic               en_q, en_d;
    logic [NB_DATA-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic [NB_DATA-1:0] count_q, count_d;
    logic [4:0]         bit_ofs;

    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        sr_d    = sr_q;
        en_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        bit_ofs = {bidx_q, 3'b000};

        case (state_q)
            ST_LOAD: begin
                if (byte_valid_i) begin
                    if (bidx_q == 2'd3) begin
                        en_d   = 1'b1;
                        data_d = {byte_i, sr_q};
                        addr_d = count_q;
                        bidx_d = 2'd0;
                        sr_d   = '0;
                    end else begin
                        sr_d[bit_ofs +: NBYTE] = byte_i;
                        bidx_d = bidx_q + 2'd1;
                    end
                end
                // The strobe cycle retires the word: advance the index and decide whether loading ends.
                if (en_q) begin
                    count_d = count_q + NB_DATA'(1);
                    if (data_q == HALT_WORD) begin
                        state_d = ST_DONE;
                    end else if (count_q == LAST_IDX) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            default: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    bidx_d  = 2'd0;
                    sr_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            bidx_q  <= 2'd0;
            sr_q    <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            bidx_q  <= bidx_d;
            sr_q    <= sr_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign en_write_o   = en_q;
    assign addr_write_o = addr_q;
    assign data_write_o = data_q;
    assign word_count_o = count_q;
    assign busy_o       = (state_q == ST_LOAD);
    assign done_o       = (state_q == ST_DONE);
    assign error_o      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: load/HALT, full-rate bytes, overflow, restart and async reset.
module tb_inst_loader;
    localparam logic [31:0] HALT = 32'hfc000000;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        en_write_o;
    logic [31:0] addr_write_o;
    logic [31:0] data_write_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [31:0] word_count_o;

    inst_loader dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .en_write_o   (en_write_o),
        .addr_write_o (addr_write_o),
        .data_write_o (data_write_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .word_count_o (word_count_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    logic [31:0] s_addr[$];
    logic [31:0] s_data[$];
    int          s_cyc[$];

    always @(negedge clock_i) begin
        if (en_write_o === 1'b1) begin
            s_addr.push_back(addr_write_o);
            s_data.push_back(data_write_o);
            s_cyc.push_back(cyc);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        s_addr.delete();
        s_data.delete();
        s_cyc.delete();
    endtask

    task automatic pb(input logic [7:0] b);
        @(negedge clock_i);
        start_i      = 1'b0;
        byte_valid_i = 1'b1;
        byte_i       = b;
    endtask

    task automatic send_word(input logic [31:0] w);
        pb(w[7:0]);
        pb(w[15:8]);
        pb(w[23:16]);
        pb(w[31:24]);
    endtask

    task automatic idle(input int n);
        @(negedge clock_i);
        byte_valid_i = 1'b0;
        start_i      = 1'b0;
        repeat (n - 1) @(negedge clock_i);
    endtask

    task automatic do_start();
        @(negedge clock_i);
        byte_valid_i = 1'b0;
        start_i      = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
    endtask

    int lastc;

    initial begin
        // reset state
        #1;
        chk("rst_en", 32'(en_write_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cnt", word_count_o, 32'd0);
        repeat (2) @(negedge clock_i);
        reset_i = 1'b1;
        idle(2);

        // load two words ending in HALT, bytes at full rate
        do_start();
        chk("t2_busy", 32'(busy_o), 32'd1);
        clr();
        send_word(32'h12345678);
        send_word(HALT);
        idle(4);
        chk("t2_nstb", 32'(s_addr.size()), 32'd2);
        chk("t2_a0", s_addr[0], 32'd0);
        chk("t2_d0", s_data[0], 32'h12345678);
        chk("t2_a1", s_addr[1], 32'd1);
        chk("t2_d1", s_data[1], HALT);
        chk("t2_gap", 32'(s_cyc[1] - s_cyc[0]), 32'd4);
        chk("t2_done", 32'(done_o), 32'd1);
        chk("t2_busy0", 32'(busy_o), 32'd0);
        chk("t2_err", 32'(error_o), 32'd0);
        chk("t2_cnt", word_count_o, 32'd2);

        // bytes without start are ignored in DONE
        clr();
        send_word(32'h11223344);
        idle(4);
        chk("t5_nostb", 32'(s_addr.size()), 32'd0);
        chk("t5_done", 32'(done_o), 32'd1);

        // restart with a coincident byte: the byte is dropped
        @(negedge clock_i);
        start_i      = 1'b1;
        byte_valid_i = 1'b1;
        byte_i       = 8'hee;
        idle(1);
        chk("t5_cnt0", word_count_o, 32'd0);
        chk("t5_busy", 32'(busy_o), 32'd1);
        chk("t5_done0", 32'(done_o), 32'd0);
        send_word(32'h04030201);
        send_word(32'hdeadbeef);
        send_word(32'hcafef00d);
        lastc = cyc;
        idle(4);
        chk("t5_nstb", 32'(s_addr.size()), 32'd3);
        chk("t5_a0", s_addr[0], 32'd0);
        chk("t5_d0", s_data[0], 32'h04030201);
        chk("t3_a1", s_addr[1], 32'd1);
        chk("t3_d1", s_data[1], 32'hdeadbeef);
        chk("t3_a2", s_addr[2], 32'd2);
        chk("t3_d2", s_data[2], 32'hcafef00d);
        chk("t3_gap", 32'(s_cyc[2] - s_cyc[1]), 32'd4);
        chk("t3_lat", 32'(s_cyc[2] - lastc), 32'd1);
        chk("t3_cnt", word_count_o, 32'd3);

        // async reset mid-word
        clr();
        pb(8'h01);
        pb(8'h02);
        #2;
        reset_i = 1'b0;
        #1;
        chk("t1_en", 32'(en_write_o), 32'd0);
        chk("t1_addr", addr_write_o, 32'd0);
        chk("t1_data", data_write_o, 32'd0);
        chk("t1_cnt", word_count_o, 32'd0);
        chk("t1_busy", 32'(busy_o), 32'd0);
        idle(2);
        reset_i = 1'b1;
        idle(3);
        chk("t1_nostb", 32'(s_addr.size()), 32'd0);
        do_start();
        send_word(HALT);
        idle(4);
        chk("t1_nstb", 32'(s_addr.size()), 32'd1);
        chk("t1_a0", s_addr[0], 32'd0);
        chk("t1_done", 32'(done_o), 32'd1);

        // overflow: 128 non-HALT words plus one more
        do_start();
        clr();
        for (int i = 0; i < 129; i++) send_word(32'h100 + 32'(i));
        idle(6);
        chk("t4_nstb", 32'(s_addr.size()), 32'd128);
        for (int i = 0; i < 128 && i < s_addr.size(); i++) begin
            chk("t4_addr", s_addr[i], 32'(i));
            chk("t4_data", s_data[i], 32'h100 + 32'(i));
        end
        chk("t4_err", 32'(error_o), 32'd1);
        chk("t4_done", 32'(done_o), 32'd0);
        chk("t4_busy", 32'(busy_o), 32'd0);
        chk("t4_cnt", word_count_o, 32'd128);

        // HALT in the last slot wins over overflow
        do_start();
        clr();
        for (int i = 0; i < 127; i++) send_word(32'h5000 + 32'(i));
        send_word(HALT);
        idle(6);
        chk("t6_nstb", 32'(s_addr.size()), 32'd128);
        if (s_addr.size() == 128) begin
            chk("t6_a127", s_addr[127], 32'd127);
            chk("t6_d127", s_data[127], HALT);
        end
        chk("t6_done", 32'(done_o), 32'd1);
        chk("t6_err", 32'(error_o), 32'd0);
        chk("t6_cnt", word_count_o, 32'd128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
